// File: rtl/port_tx_pkg.sv
// Shared definitions for the port_tx_responder serial output peripheral:
// FSM state encoding, default geometry and the idle line level.
package port_tx_pkg;

    localparam int DEF_DATA_SIZE    = 8;
    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_FIFO_DEPTH   = 4;

    localparam logic TX_IDLE = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_STOP   = 3'd3;
    localparam state_t ST_PARITY = 3'd4;

endpackage

// File: rtl/port_tx_fifo.sv
// Small synchronous FIFO with first-word-fall-through output; a push is
// accepted when full only if a pop happens on the same edge.
module port_tx_fifo
    import port_tx_pkg::*;
#(
    parameter int DATA_SIZE  = DEF_DATA_SIZE,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic [DATA_SIZE-1:0]          data_i,
    output logic [DATA_SIZE-1:0]          data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic                 do_push, do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/port_tx_responder.sv
// Port-write responder: queues R0 bytes and sends them as 8N1 UART frames.
// Define PORT_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module port_tx_responder
    import port_tx_pkg::*;
#(
    parameter int DATA_SIZE    = DEF_DATA_SIZE,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sel_port,
    input  logic [DATA_SIZE-1:0] port_data,
    output logic                 tx,
    output logic                 busy,
    output logic                 full,
    output logic                 overflow
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT    = IW'(DATA_SIZE - 1);
`ifdef PORT_TX_PARITY_EN
    localparam state_t AFTER_DATA = ST_PARITY;
`else
    localparam state_t AFTER_DATA = ST_STOP;
`endif

    state_t                      state_q, state_d;
    logic [BW-1:0]               baud_q, baud_d;
    logic [IW-1:0]               bit_q, bit_d;
    logic [DATA_SIZE-1:0]        shift_q, shift_d;
    logic                        tx_q, tx_d;
    logic                        ovf_q, ovf_d;
    logic                        par_q, par_d;
    logic                        pop, baud_done;
    logic                        fifo_full, fifo_empty;
    logic [DATA_SIZE-1:0]        head;
    logic [$clog2(FIFO_DEPTH):0] count;

    port_tx_fifo #(
        .DATA_SIZE  (DATA_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (sel_port),
        .pop_i   (pop),
        .data_i  (port_data),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    assign pop       = (state_q == ST_IDLE) & ~fifo_empty;
    assign baud_done = (baud_q == '0);
    assign ovf_d     = ovf_q | (sel_port & fifo_full & ~pop);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    shift_d = head;
                    par_d   = ^head;
                    baud_d  = BAUD_RELOAD;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_d  = BAUD_RELOAD;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_d  = BAUD_RELOAD;
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) state_d = AFTER_DATA;
                    else                   bit_d   = bit_q + IW'(1);
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
`ifdef PORT_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_done) begin
                    baud_d  = BAUD_RELOAD;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
`endif
            ST_STOP: begin
                if (baud_done) state_d = ST_IDLE;
                else           baud_d  = baud_q - BW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The line level follows the current state, so tx trails the FSM by one edge.
    always_comb begin
        tx_d = TX_IDLE;
        case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[0];
`ifdef PORT_TX_PARITY_EN
            ST_PARITY: tx_d = par_q;
`endif
            default:   tx_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= TX_IDLE;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    assign tx       = tx_q;
    assign overflow = ovf_q;
    assign full     = fifo_full;
    assign busy     = (state_q != ST_IDLE) | (count != '0);

endmodule

// File: tb/tb_port_tx_responder.sv
// Scoreboard bench for port_tx_responder: a queue/timer reference model predicts
// frames and flags; a negedge monitor decodes tx and compares.
module tb_port_tx_responder;

    localparam int DS    = 8;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef PORT_TX_PARITY_EN
    localparam int NB = DS + 3;
`else
    localparam int NB = DS + 2;
`endif
    localparam int FLEN = NB * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sel_port = 1'b0;
    logic [DS-1:0] port_data = '0;
    logic          tx, busy, full, overflow;

    always #5 clk = ~clk;

    port_tx_responder #(
        .DATA_SIZE    (DS),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sel_port  (sel_port),
        .port_data (port_data),
        .tx        (tx),
        .busy      (busy),
        .full      (full),
        .overflow  (overflow)
    );

    typedef struct packed {
        logic [DS-1:0] data;
        logic [31:0]   fall;
    } exp_t;

    exp_t          exp_q[$];
    logic [DS-1:0] mq[$];
    int            rem = 0;
    bit            m_ovf = 1'b0;
    int            cyc = 0;
    bit            rst_s = 1'b1;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", nm, cyc, act, req);
        end
    endtask

    // Reference model: a byte queue plus a transmitter-occupancy timer.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        rst_s = rst;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            rem   = 0;
            m_ovf = 1'b0;
        end else begin
            if (rem == 0 && mq.size() > 0) begin
                e.data = mq.pop_front();
                e.fall = 32'(cyc + 1);
                exp_q.push_back(e);
                rem = FLEN;
            end else if (rem > 0) begin
                rem--;
            end
            if (sel_port) begin
                if (mq.size() < DEPTH) mq.push_back(port_data);
                else                   m_ovf = 1'b1;
            end
        end
    end

    // Monitor: checks flags each cycle and decodes frames bit by bit.
    bit            m_act = 1'b0;
    int            m_pos = 0;
    int            bad_cycles = 0;
    logic          prev_tx = 1'b1;
    logic [NB-1:0] fbits;
    exp_t          cur;

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("busy", busy, (rem > 0 || mq.size() > 0));
            chk("full", full, (mq.size() == DEPTH));
            chk("overflow", overflow, m_ovf);
            if (rst_s) begin
                chk("tx_in_reset", tx, 1);
                m_act = 1'b0;
            end else if (!m_act && prev_tx === 1'b1 && tx === 1'b0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_frame at cycle %0d: tx fell, required idle", cyc);
                end else begin
                    cur = exp_q.pop_front();
                    chk("start_fall_cycle", cyc, cur.fall);
                    fbits = '1;
                    fbits[0] = 1'b0;
                    for (int i = 0; i < DS; i++) fbits[1+i] = cur.data[i];
`ifdef PORT_TX_PARITY_EN
                    fbits[DS+1] = ^cur.data;
`endif
                    m_act = 1'b1;
                    m_pos = 0;
                    bad_cycles = 0;
                end
            end
            if (m_act) begin
                if (tx !== fbits[m_pos / CPB]) bad_cycles++;
                if (m_pos % CPB == CPB - 1) begin
                    n_cmp++;
                    if (bad_cycles != 0) begin
                        n_err++;
                        $display("FAIL frame_bit byte=%02h bit=%0d: %0d of %0d cycles wrong, required level %0b",
                                 cur.data, m_pos / CPB, bad_cycles, CPB, fbits[m_pos / CPB]);
                    end
                    bad_cycles = 0;
                end
                m_pos++;
                if (m_pos == FLEN) m_act = 1'b0;
            end
        end
        prev_tx = tx;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DS-1:0] d);
        sel_port  = 1'b1;
        port_data = d;
        step();
        sel_port  = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (!busy && !m_act) begin
                done = 1'b1;
                break;
            end
            step();
        end
        chk("wait_idle_timeout", done, 1);
        repeat (3) step();
    endtask

    initial begin
        // Idle after reset
        step();
        step();
        rst = 1'b0;
        repeat (20) step();
        chk("idle_tx", tx, 1);
        chk("idle_busy", busy, 0);

        // Single byte, then back-to-back pair
        send(8'hA5);
        wait_idle();
        send(8'h01);
        send(8'h80);
        wait_idle();

        // Overflow on the sixth consecutive strobe
        for (int i = 0; i < 6; i++) send(8'(8'h10 + i));
        chk("overflow_set", overflow, 1);
        chk("full_set", full, 1);
        wait_idle();
        chk("overflow_sticky", overflow, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("overflow_cleared", overflow, 0);

        // Push coinciding with a pop while full
        for (int i = 0; i < 5; i++) send(8'(8'h20 + i));
        for (int i = 0; i < 500; i++) begin
            if (rem == 0) break;
            step();
        end
        chk("full_before_pushpop", full, 1);
        send(8'h3C);
        chk("full_after_pushpop", full, 1);
        chk("overflow_after_pushpop", overflow, 0);
        wait_idle();

        // Reset during DATA bit 3 with two bytes queued
        send(8'hFF);
        send(8'h11);
        send(8'h22);
        repeat (68) step();
        chk("busy_before_rst", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("tx_after_rst", tx, 1);
        chk("busy_after_rst", busy, 0);
        repeat (200) step();

        // Parity-relevant byte
        send(8'h07);
        wait_idle();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            sel_port  = ($urandom_range(0, 99) < 3);
            port_data = 8'($urandom);
            rst       = ($urandom_range(0, 1499) == 0);
            step();
        end
        sel_port = 1'b0;
        rst      = 1'b0;
        wait_idle();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
